uart_irq_baud_monitor: RTL
==========================

// Module: uart_irq_baud_monitor
//
// PURPOSE
//   Receive-side observer for the UART interrupt/baud interface. It takes the DUT's IRQ and
//   baud_out outputs and does three things:
//   - synchronises both signals;
//   - turns IRQ rising edges into a sticky pending flag with an acknowledge handshake;
//   - measures the baud_out period in CLK cycles and reports lock once the period is stable.
//   Sits in the testbench/host side, consuming the interface the UART drives.
//
// PARAMETERS
//   SYNC_STAGES  2   synchroniser depth for IRQ and baud_out (>=2)
//   PERIOD_W     16  width of baud period counter/result
//   CNT_W        8   width of saturating IRQ rising-edge counter
//   STABLE_N     4   consecutive identical periods required for lock (>=2)
//
// PORTS
//   CLK           in   1         clock; all logic on rising edge
//   RST           in   1         synchronous reset, active-high
//   IRQ           in   1         UART interrupt request (async to CLK)
//   baud_out      in   1         UART baud clock output (async to CLK)
//   irq_ack       in   1         host acknowledge; clears irq_pending
//   irq_level     out  1         synchronised IRQ level
//   irq_pending   out  1         sticky: set on IRQ rising edge
//   irq_rise_cnt  out  CNT_W     IRQ rising edges seen, saturating
//   baud_period   out  PERIOD_W  last measured baud_out period, CLK cycles
//   baud_valid    out  1         1-cycle pulse when baud_period updates
//   baud_locked   out  1         STABLE_N consecutive equal periods seen
//   baud_timeout  out  1         sticky: period counter saturated
//
// BEHAVIOUR
//   Reset
//   - RST=1 at a CLK edge clears all synchroniser flops, counters, the FSM and every output to 0.
//   - FSM returns to IDLE; RST mid-measurement discards the partial count.
//
//   Synchronisers
//   - SYNC_STAGES flops each on IRQ and baud_out, giving irq_s and baud_s.
//   - irq_level = irq_s.
//   - Edge detection uses one further registered copy: rise = s & ~s_d.
//
//   Interrupt path
//   - Latency: IRQ 0->1 is reflected in irq_pending SYNC_STAGES+1 cycles later.
//   - irq_pending: set on irq_rise; cleared on irq_ack; irq_rise and irq_ack in the same cycle
//     leave it set (rise wins).
//   - irq_ack while not pending has no effect.
//   - irq_rise_cnt increments on each irq_rise and holds at 2**CNT_W-1; it is never cleared
//     by irq_ack.
//   - IRQ falling edges affect only irq_level.
//
//   Baud FSM (states IDLE, MEASURE)
//   - IDLE: pcnt held at 0. On baud_rise, set pcnt=1 and go to MEASURE.
//   - MEASURE: pcnt increments each cycle without a baud_rise.
//     - On baud_rise: baud_period<=pcnt, baud_valid=1 for that one cycle, pcnt<=1, stay in
//       MEASURE.
//     - Result: baud_out with period P CLK cycles reports baud_period=P.
//     - If pcnt reaches 2**PERIOD_W-1 without a baud_rise: set baud_timeout (sticky until RST),
//       clear baud_locked and the stability count, go to IDLE. baud_period holds its last value.
//   - A baud_rise in the same cycle as saturation counts as a rise: measure normally, no timeout.
//
//   Lock
//   - stab counter (saturating at STABLE_N): on each baud_valid, stab<=stab+1 if the new period
//     equals the previous baud_period, else stab<=1.
//   - The first measurement after IDLE sets stab=1.
//   - baud_locked=1 whenever stab==STABLE_N, updating in the same cycle as baud_valid;
//     it drops in the cycle a mismatching period is captured.
//
//   Width rule: all counters are unsigned and never wrap.
//
// TESTING
//   1 Reset: drive RST 3 cycles with IRQ=1 and baud_out toggling
//     -> all outputs 0 during reset; FSM in IDLE afterwards.
//   2 IRQ pulse: IRQ 0->1 at cycle 10 (SYNC_STAGES=2) -> irq_pending=1 at cycle 13; irq_rise_cnt=1;
//     irq_ack at cycle 20 -> irq_pending=0 at cycle 21.
//   3 Ack/rise collision: irq_ack asserted in the same cycle as the second irq_rise
//     -> irq_pending stays 1; irq_rise_cnt=2.
//   4 Baud lock: baud_out period 16 (8 high/8 low) -> baud_period=16, baud_valid every 16 cycles;
//     baud_locked=1 on the 4th valid.
//     Then switch to period 20 -> baud_locked=0 on the first valid with 20, re-lock on the 4th.
//   5 Timeout: PERIOD_W=8, baud_out stuck low after one rise -> baud_timeout=1 at pcnt=255;
//     baud_locked=0; FSM in IDLE. Resume toggling -> measurements restart; timeout stays 1.
//   6 Saturation/reset: CNT_W=4, 20 IRQ pulses -> irq_rise_cnt=15.
//     RST mid-MEASURE -> baud_period=0; the first valid after reset reports a full period.

Source files
------------

// File: rtl/uart_irq_baud_monitor.sv
// uart_irq_baud_monitor
//
// Receive-side observer for a UART's interrupt and baud clock outputs.
// Both inputs are asynchronous to CLK and are synchronised first. IRQ rising
// edges become a sticky pending flag with an acknowledge handshake, plus a
// saturating edge counter. The baud_out period is measured in CLK cycles, and
// lock is reported once STABLE_N consecutive equal periods have been seen.
//
// Ports:
//   CLK           clock, all logic on the rising edge
//   RST           synchronous active-high reset
//   IRQ           UART interrupt request (async)
//   baud_out      UART baud clock (async)
//   irq_ack       host acknowledge, clears irq_pending
//   irq_level     synchronised IRQ level
//   irq_pending   sticky flag, set on an IRQ rising edge
//   irq_rise_cnt  saturating count of IRQ rising edges
//   baud_period   last measured baud_out period in CLK cycles
//   baud_valid    one-cycle pulse when baud_period updates
//   baud_locked   STABLE_N consecutive equal periods seen
//   baud_timeout  sticky flag, period counter saturated without an edge

module uart_irq_baud_monitor #(
  parameter int SYNC_STAGES = 2,
  parameter int PERIOD_W    = 16,
  parameter int CNT_W       = 8,
  parameter int STABLE_N    = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                IRQ,
  input  logic                baud_out,
  input  logic                irq_ack,
  output logic                irq_level,
  output logic                irq_pending,
  output logic [CNT_W-1:0]    irq_rise_cnt,
  output logic [PERIOD_W-1:0] baud_period,
  output logic                baud_valid,
  output logic                baud_locked,
  output logic                baud_timeout
);

  localparam int STAB_W = $clog2(STABLE_N + 1);

  localparam logic [PERIOD_W-1:0] PCNT_MAX = '1;
  localparam logic [PERIOD_W-1:0] PCNT_ONE = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX  = '1;
  localparam logic [CNT_W-1:0]    CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [STAB_W-1:0]   STAB_MAX = STAB_W'(STABLE_N);
  localparam logic [STAB_W-1:0]   STAB_ONE = {{(STAB_W-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, MEASURE} state_t;

  logic [SYNC_STAGES-1:0] irq_sync;
  logic [SYNC_STAGES-1:0] baud_sync;
  logic                   irq_d;
  logic                   baud_d;
  logic                   irq_s;
  logic                   baud_s;
  logic                   irq_rise;
  logic                   baud_rise;

  state_t                 state;
  state_t                 state_next;
  logic [PERIOD_W-1:0]    pcnt;
  logic [STAB_W-1:0]      stab;
  logic                   start;
  logic                   capture;
  logic                   expire;

  // Synchroniser chains plus one extra registered copy for edge detection.
  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_sync  <= '0;
      baud_sync <= '0;
      irq_d     <= 1'b0;
      baud_d    <= 1'b0;
    end else begin
      irq_sync  <= {irq_sync[SYNC_STAGES-2:0], IRQ};
      baud_sync <= {baud_sync[SYNC_STAGES-2:0], baud_out};
      irq_d     <= irq_s;
      baud_d    <= baud_s;
    end
  end

  assign irq_s     = irq_sync[SYNC_STAGES-1];
  assign baud_s    = baud_sync[SYNC_STAGES-1];
  assign irq_rise  = irq_s & ~irq_d;
  assign baud_rise = baud_s & ~baud_d;
  assign irq_level = irq_s;

  // Pending flag: a new rising edge takes priority over an acknowledge in
  // the same cycle, so an interrupt is never lost. The edge counter is
  // independent of the handshake and sticks at its maximum.
  always_ff @(posedge CLK) begin
    if (RST) begin
      irq_pending  <= 1'b0;
      irq_rise_cnt <= '0;
    end else begin
      if (irq_rise) begin
        irq_pending <= 1'b1;
      end else if (irq_ack) begin
        irq_pending <= 1'b0;
      end
      if (irq_rise && (irq_rise_cnt != CNT_MAX)) begin
        irq_rise_cnt <= irq_rise_cnt + CNT_ONE;
      end
    end
  end

  // Baud FSM state register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: the first edge opens a measurement; saturation without an
  // edge abandons it. An edge in the saturating cycle still counts.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (baud_rise) state_next = MEASURE;
      MEASURE: if (!baud_rise && (pcnt == PCNT_MAX)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM strobes driving the measurement datapath.
  always_comb begin
    start   = 1'b0;
    capture = 1'b0;
    expire  = 1'b0;
    case (state)
      IDLE:    start = baud_rise;
      MEASURE: begin
        capture = baud_rise;
        expire  = !baud_rise && (pcnt == PCNT_MAX);
      end
      default: ;
    endcase
  end

  // Period counter and result registers. pcnt restarts at 1 on an edge so
  // that a baud_out period of P cycles captures exactly P. On expiry the
  // stability history is dropped but the last good period is kept.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pcnt         <= '0;
      baud_period  <= '0;
      baud_valid   <= 1'b0;
      baud_timeout <= 1'b0;
      stab         <= '0;
    end else begin
      baud_valid <= capture;
      if (start || capture) begin
        pcnt <= PCNT_ONE;
      end else if (expire) begin
        pcnt <= '0;
      end else if (state == MEASURE) begin
        pcnt <= pcnt + PCNT_ONE;
      end

      if (capture) begin
        baud_period <= pcnt;
        // stab==0 marks the first measurement after IDLE, which must not
        // be compared against a stale period.
        if ((stab != '0) && (pcnt == baud_period)) begin
          if (stab != STAB_MAX) stab <= stab + STAB_ONE;
        end else begin
          stab <= STAB_ONE;
        end
      end

      if (expire) begin
        baud_timeout <= 1'b1;
        stab         <= '0;
      end
    end
  end

  assign baud_locked = (stab == STAB_MAX);

endmodule
